// File: rtl/ika2151_pkg.sv
// Shared definitions for the IKA2151 register-write sequencer: FSM encoding,
// default bus timing constants and the buffered command record.
package ika2151_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STB,
    ST_A_HOLD,
    ST_D_SETUP,
    ST_D_STB,
    ST_D_HOLD,
    ST_P_SETUP,
    ST_P_STB,
    ST_P_HOLD,
    ST_REL
  } wrseq_state_t;

  localparam int DEF_FIFO_AW   = 4;
  localparam int DEF_SETUP_TK  = 2;
  localparam int DEF_STROBE_TK = 4;
  localparam int DEF_HOLD_TK   = 2;
  localparam int DEF_BUSY_TMO  = 255;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_cmd_t;

endpackage

// File: rtl/ika2151_wrseq_if.sv
// Host command handshake plus the IKA2151 chip-bus pins, seen from the sequencer
// (slave) and from the host/core side (master).
interface ika2151_wrseq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       cs_n;
  logic       rd_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d;
  logic [7:0] status;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, status,
    output cmd_ready, cs_n, rd_n, wr_n, a0, d
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_data, status,
    input  cmd_ready, cs_n, rd_n, wr_n, a0, d
  );
endinterface

// File: rtl/ika2151_cmdfifo.sv
// Synchronous first-word-fall-through FIFO of (addr,data) write commands with an
// occupancy count; the caller guarantees no push when full and no pop when empty.
module ika2151_cmdfifo
  import ika2151_pkg::*;
#(
  parameter int FIFO_AW = DEF_FIFO_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  wr_cmd_t          wdata,
  output wr_cmd_t          rdata,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 1 << FIFO_AW;

  wr_cmd_t            mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage carries data only; emptiness is defined by the pointers and level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (level == (FIFO_AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/ika2151_wrseq.sv
// Replays buffered register writes on the IKA2151 bus: address cycle, data cycle,
// then status polling until the busy flag clears or the poll budget runs out.
module ika2151_wrseq
  import ika2151_pkg::*;
#(
  parameter int FIFO_AW   = DEF_FIFO_AW,
  parameter int SETUP_TK  = DEF_SETUP_TK,
  parameter int STROBE_TK = DEF_STROBE_TK,
  parameter int HOLD_TK   = DEF_HOLD_TK,
  parameter int BUSY_TMO  = DEF_BUSY_TMO
) (
  input  logic             i_EMUCLK,
  input  logic             i_MRST_n,
  input  logic             i_phiM_PCEN_n,
  ika2151_wrseq_if.slave   bus,
  output logic             o_IDLE,
  output logic [FIFO_AW:0] o_LEVEL,
  output logic             o_TIMEOUT
);
  wrseq_state_t state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [7:0]   polls_q, polls_d;
  logic         busy_q, busy_d;
  logic         tmo_d;
  wr_cmd_t      cmd_q, cmd_cur, fifo_rdata;
  logic         push, pop, full, empty;
  logic         tick, done;
  logic         cs_d, rd_d, wr_d, a0_d;
  logic [7:0]   d_d;
  logic         cs_q, rd_q, wr_q, a0_q;
  logic [7:0]   d_q;
  logic         unused_status;

  // Remaining ticks after entry, so a phase of N ticks loads N-1.
  function automatic logic [7:0] phase_len(input wrseq_state_t s);
    case (s)
      ST_A_SETUP, ST_D_SETUP, ST_P_SETUP:       return 8'(SETUP_TK - 1);
      ST_A_STB, ST_D_STB, ST_P_STB:             return 8'(STROBE_TK - 1);
      ST_A_HOLD, ST_D_HOLD, ST_P_HOLD, ST_REL:  return 8'(HOLD_TK - 1);
      default:                                  return 8'd0;
    endcase
  endfunction

  ika2151_cmdfifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (i_EMUCLK),
    .rst_n (i_MRST_n),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.cmd_addr, bus.cmd_data}),
    .rdata (fifo_rdata),
    .level (o_LEVEL),
    .full  (full),
    .empty (empty)
  );

  assign push          = bus.cmd_valid & ~full;
  assign bus.cmd_ready = ~full;
  assign o_IDLE        = (state_q == ST_IDLE) & empty;
  assign tick          = ~i_phiM_PCEN_n;
  assign done          = tick & (cnt_q == 8'd0);
  assign cmd_cur       = pop ? fifo_rdata : cmd_q;
  assign unused_status = ^bus.status[6:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    polls_d = polls_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    pop     = 1'b0;
    if (tick && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    case (state_q)
      ST_IDLE: begin
        polls_d = 8'd0;
        if (tick && !empty) begin
          pop     = 1'b1;
          state_d = ST_A_SETUP;
        end
      end
      ST_A_SETUP: if (done) state_d = ST_A_STB;
      ST_A_STB:   if (done) state_d = ST_A_HOLD;
      ST_A_HOLD:  if (done) state_d = ST_D_SETUP;
      ST_D_SETUP: if (done) state_d = ST_D_STB;
      ST_D_STB:   if (done) state_d = ST_D_HOLD;
      ST_D_HOLD:  if (done) state_d = ST_P_SETUP;
      ST_P_SETUP: if (done) state_d = ST_P_STB;
      ST_P_STB: begin
        if (done) begin
          busy_d  = bus.status[7];
          state_d = ST_P_HOLD;
        end
      end
      ST_P_HOLD: begin
        if (done) begin
          if (!busy_q) begin
            state_d = ST_REL;
          end else if (polls_q == 8'(BUSY_TMO)) begin
            tmo_d   = 1'b1;
            state_d = ST_REL;
          end else begin
            polls_d = (polls_q == 8'hFF) ? polls_q : polls_q + 8'd1;
            state_d = ST_P_SETUP;
          end
        end
      end
      ST_REL:  if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) cnt_d = phase_len(state_d);
  end

  // Bus pins are decoded from the next state and registered, so they change
  // together with the state and never glitch.
  always_comb begin
    cs_d = 1'b1;
    rd_d = 1'b1;
    wr_d = 1'b1;
    a0_d = 1'b0;
    d_d  = 8'd0;
    case (state_d)
      ST_A_SETUP, ST_A_HOLD: begin
        cs_d = 1'b0;
        d_d  = cmd_cur.addr;
      end
      ST_A_STB: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        d_d  = cmd_cur.addr;
      end
      ST_D_SETUP, ST_D_HOLD: begin
        cs_d = 1'b0;
        a0_d = 1'b1;
        d_d  = cmd_cur.data;
      end
      ST_D_STB: begin
        cs_d = 1'b0;
        wr_d = 1'b0;
        a0_d = 1'b1;
        d_d  = cmd_cur.data;
      end
      ST_P_SETUP, ST_P_HOLD: begin
        cs_d = 1'b0;
        a0_d = 1'b1;
      end
      ST_P_STB: begin
        cs_d = 1'b0;
        rd_d = 1'b0;
        a0_d = 1'b1;
      end
      ST_REL:  a0_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      polls_q   <= 8'd0;
      busy_q    <= 1'b0;
      o_TIMEOUT <= 1'b0;
      cs_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      a0_q      <= 1'b0;
      d_q       <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      polls_q   <= polls_d;
      busy_q    <= busy_d;
      o_TIMEOUT <= tmo_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      a0_q      <= a0_d;
      d_q       <= d_d;
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (pop) cmd_q <= fifo_rdata;
  end

  assign bus.cs_n = cs_q;
  assign bus.rd_n = rd_q;
  assign bus.wr_n = wr_q;
  assign bus.a0   = a0_q;
  assign bus.d    = d_q;

endmodule

// File: tb/tb_ika2151_wrseq.sv
// Directed bench for ika2151_wrseq: a negedge monitor paces phiM, models the core
// status byte and logs write strobes; one task per scenario checks the log.
module tb_ika2151_wrseq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pcen_n = 1'b1;
  logic       idle;
  logic       timeout;
  logic [4:0] level;

  ika2151_wrseq_if bus ();

  ika2151_wrseq #(
    .FIFO_AW(4), .SETUP_TK(2), .STROBE_TK(4), .HOLD_TK(2), .BUSY_TMO(3)
  ) dut (
    .i_EMUCLK      (clk),
    .i_MRST_n      (rst_n),
    .i_phiM_PCEN_n (pcen_n),
    .bus           (bus),
    .o_IDLE        (idle),
    .o_LEVEL       (level),
    .o_TIMEOUT     (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic hold = 1'b0;
  logic stuck = 1'b0;
  int   busy_until = 0;

  int         wr_cnt = 0, rd_cnt = 0, tmo_cnt = 0, busy_ticks = 0, overlap = 0, wr_acc = 0;
  logic       wr_a0 [128];
  logic [7:0] wr_d  [128];
  int         wr_len[128];
  logic       prev_wr = 1'b1, prev_rd = 1'b1;

  // phiM ticks on every other EMUCLK edge; counts refer to the upcoming posedge.
  always @(negedge clk) begin
    pcen_n = hold ? 1'b1 : ~pcen_n;
    if (!bus.wr_n && prev_wr && wr_cnt < 128) begin
      wr_a0[wr_cnt] = bus.a0;
      wr_d[wr_cnt]  = bus.d;
      wr_acc        = 0;
    end
    if (!bus.wr_n && !pcen_n) wr_acc++;
    if (bus.wr_n && !prev_wr && wr_cnt < 128) begin
      wr_len[wr_cnt] = wr_acc;
      wr_cnt++;
    end
    if (!bus.rd_n && prev_rd) begin
      bus.status = (stuck || rd_cnt < busy_until) ? 8'h80 : 8'h00;
      rd_cnt++;
    end
    if (!bus.wr_n && !bus.rd_n) overlap++;
    if (timeout) tmo_cnt++;
    if (!idle && !pcen_n) busy_ticks++;
    prev_wr = bus.wr_n;
    prev_rd = bus.rd_n;
  end

  task automatic push(input logic [7:0] a, input logic [7:0] dat);
    int n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_data  = dat;
    while (!bus.cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: ready=%0b, required 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    repeat (2) @(negedge clk);
    while (!idle && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL %s: idle=%0b after %0d cycles, required 1", name, idle, n);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 9;
    if (bus.cs_n !== 1'b1)      begin errors++; $display("FAIL rst_cs_n: got %0b, required 1", bus.cs_n); end
    if (bus.rd_n !== 1'b1)      begin errors++; $display("FAIL rst_rd_n: got %0b, required 1", bus.rd_n); end
    if (bus.wr_n !== 1'b1)      begin errors++; $display("FAIL rst_wr_n: got %0b, required 1", bus.wr_n); end
    if (bus.a0 !== 1'b0)        begin errors++; $display("FAIL rst_a0: got %0b, required 0", bus.a0); end
    if (bus.d !== 8'h00)        begin errors++; $display("FAIL rst_d: got %02h, required 00", bus.d); end
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b, required 1", bus.cmd_ready); end
    if (idle !== 1'b1)          begin errors++; $display("FAIL rst_idle: got %0b, required 1", idle); end
    if (level !== 5'd0)         begin errors++; $display("FAIL rst_level: got %0d, required 0", level); end
    if (timeout !== 1'b0)       begin errors++; $display("FAIL rst_timeout: got %0b, required 0", timeout); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_write();
    int bw = wr_cnt, br = rd_cnt, bt = tmo_cnt, bb = busy_ticks, bo = overlap;
    stuck = 1'b0;
    busy_until = rd_cnt;
    push(8'h28, 8'h4A);
    wait_idle(400, "single_idle");
    checks += 11;
    if (wr_cnt - bw !== 2)      begin errors++; $display("FAIL single_wr_count: got %0d, required 2", wr_cnt - bw); end
    if (wr_a0[bw] !== 1'b0)     begin errors++; $display("FAIL single_addr_a0: got %0b, required 0", wr_a0[bw]); end
    if (wr_d[bw] !== 8'h28)     begin errors++; $display("FAIL single_addr_d: got %02h, required 28", wr_d[bw]); end
    if (wr_a0[bw+1] !== 1'b1)   begin errors++; $display("FAIL single_data_a0: got %0b, required 1", wr_a0[bw+1]); end
    if (wr_d[bw+1] !== 8'h4A)   begin errors++; $display("FAIL single_data_d: got %02h, required 4A", wr_d[bw+1]); end
    if (wr_len[bw] !== 4)       begin errors++; $display("FAIL single_addr_len: got %0d ticks, required 4", wr_len[bw]); end
    if (wr_len[bw+1] !== 4)     begin errors++; $display("FAIL single_data_len: got %0d ticks, required 4", wr_len[bw+1]); end
    if (rd_cnt - br !== 1)      begin errors++; $display("FAIL single_reads: got %0d, required 1", rd_cnt - br); end
    if (tmo_cnt - bt !== 0)     begin errors++; $display("FAIL single_timeout: got %0d, required 0", tmo_cnt - bt); end
    // pop tick plus 3*(2+4+2)+2 phase ticks
    if (busy_ticks - bb !== 27) begin errors++; $display("FAIL single_latency: got %0d ticks, required 27", busy_ticks - bb); end
    if (overlap - bo !== 0)     begin errors++; $display("FAIL single_overlap: got %0d, required 0", overlap - bo); end
  endtask

  task automatic test_busy_poll();
    int bw = wr_cnt, br = rd_cnt, bt = tmo_cnt, bo = overlap;
    stuck = 1'b0;
    busy_until = rd_cnt + 3;
    push(8'h10, 8'h01);
    push(8'h11, 8'h02);
    wait_idle(1500, "busy_idle");
    checks += 7;
    if (rd_cnt - br !== 5)    begin errors++; $display("FAIL busy_reads: got %0d, required 5", rd_cnt - br); end
    if (tmo_cnt - bt !== 0)   begin errors++; $display("FAIL busy_timeout: got %0d, required 0", tmo_cnt - bt); end
    if (wr_cnt - bw !== 4)    begin errors++; $display("FAIL busy_wr_count: got %0d, required 4", wr_cnt - bw); end
    if (wr_d[bw] !== 8'h10)   begin errors++; $display("FAIL busy_first_addr: got %02h, required 10", wr_d[bw]); end
    if (wr_d[bw+2] !== 8'h11) begin errors++; $display("FAIL busy_next_addr: got %02h, required 11", wr_d[bw+2]); end
    if (wr_d[bw+3] !== 8'h02) begin errors++; $display("FAIL busy_next_data: got %02h, required 02", wr_d[bw+3]); end
    if (overlap - bo !== 0)   begin errors++; $display("FAIL busy_overlap: got %0d, required 0", overlap - bo); end
  endtask

  task automatic test_timeout();
    int bw = wr_cnt, br = rd_cnt, bt = tmo_cnt;
    stuck = 1'b1;
    push(8'h20, 8'h33);
    wait_idle(1000, "tmo_idle");
    stuck = 1'b0;
    checks += 3;
    if (rd_cnt - br !== 4)  begin errors++; $display("FAIL tmo_reads: got %0d, required 4", rd_cnt - br); end
    if (tmo_cnt - bt !== 1) begin errors++; $display("FAIL tmo_pulses: got %0d, required 1", tmo_cnt - bt); end
    if (wr_cnt - bw !== 2)  begin errors++; $display("FAIL tmo_wr_count: got %0d, required 2", wr_cnt - bw); end
  endtask

  task automatic test_freeze();
    int bw = wr_cnt;
    int n = 0;
    busy_until = rd_cnt;
    push(8'h55, 8'h66);
    while (bus.wr_n && n < 200) begin
      @(negedge clk);
      n++;
    end
    hold = 1'b1;
    repeat (22) @(negedge clk);
    checks += 6;
    if (bus.wr_n !== 1'b0) begin errors++; $display("FAIL freeze_wr_n: got %0b, required 0", bus.wr_n); end
    if (bus.cs_n !== 1'b0) begin errors++; $display("FAIL freeze_cs_n: got %0b, required 0", bus.cs_n); end
    if (bus.a0 !== 1'b0)   begin errors++; $display("FAIL freeze_a0: got %0b, required 0", bus.a0); end
    if (bus.d !== 8'h55)   begin errors++; $display("FAIL freeze_d: got %02h, required 55", bus.d); end
    if (level !== 5'd0)    begin errors++; $display("FAIL freeze_level: got %0d, required 0", level); end
    if (wr_cnt !== bw)     begin errors++; $display("FAIL freeze_wr_count: got %0d, required %0d", wr_cnt, bw); end
    hold = 1'b0;
    wait_idle(400, "freeze_idle");
    checks += 2;
    if (wr_len[bw] !== 4)   begin errors++; $display("FAIL freeze_addr_len: got %0d ticks, required 4", wr_len[bw]); end
    if (wr_len[bw+1] !== 4) begin errors++; $display("FAIL freeze_data_len: got %0d ticks, required 4", wr_len[bw+1]); end
  endtask

  task automatic test_back_to_back();
    int bw = wr_cnt, br = rd_cnt;
    busy_until = rd_cnt;
    hold = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      push(8'h30 + 8'(i), 8'hA0 + 8'(i));
      if (i == 14) begin
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || level !== 5'd15) begin
          errors++;
          $display("FAIL b2b_level15: ready=%0b level=%0d, required 1/15", bus.cmd_ready, level);
        end
      end
    end
    @(negedge clk);
    checks += 3;
    if (level !== 5'd16)        begin errors++; $display("FAIL b2b_full_level: got %0d, required 16", level); end
    if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %0b, required 0", bus.cmd_ready); end
    if (idle !== 1'b0)          begin errors++; $display("FAIL b2b_full_idle: got %0b, required 0", idle); end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 8'h7F;
    bus.cmd_data  = 8'h7F;
    repeat (4) @(negedge clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (level !== 5'd16) begin errors++; $display("FAIL b2b_17th_rejected: level=%0d, required 16", level); end
    hold = 1'b0;
    wait_idle(4000, "b2b_idle");
    checks += 2;
    if (wr_cnt - bw !== 32) begin errors++; $display("FAIL b2b_wr_count: got %0d, required 32", wr_cnt - bw); end
    if (rd_cnt - br !== 16) begin errors++; $display("FAIL b2b_reads: got %0d, required 16", rd_cnt - br); end
    for (int i = 0; i < 16; i++) begin
      checks += 2;
      if (wr_d[bw+2*i] !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_addr[%0d]: got %02h, required %02h", i, wr_d[bw+2*i], 8'h30 + 8'(i));
      end
      if (wr_d[bw+2*i+1] !== 8'hA0 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %02h, required %02h", i, wr_d[bw+2*i+1], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int bw;
    busy_until = rd_cnt;
    push(8'h01, 8'h02);
    push(8'h03, 8'h04);
    while (!(bus.wr_n === 1'b0 && bus.a0 === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(bus.wr_n === 1'b0 && bus.a0 === 1'b1)) begin
      errors++;
      $display("FAIL mid_reach_dstb: wr_n=%0b a0=%0b, required 0/1", bus.wr_n, bus.a0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.wr_n !== 1'b1) begin errors++; $display("FAIL mid_wr_n: got %0b, required 1", bus.wr_n); end
    if (bus.cs_n !== 1'b1) begin errors++; $display("FAIL mid_cs_n: got %0b, required 1", bus.cs_n); end
    if (bus.rd_n !== 1'b1) begin errors++; $display("FAIL mid_rd_n: got %0b, required 1", bus.rd_n); end
    if (level !== 5'd0)    begin errors++; $display("FAIL mid_level: got %0d, required 0", level); end
    if (idle !== 1'b1)     begin errors++; $display("FAIL mid_idle: got %0b, required 1", idle); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    bw = wr_cnt;
    repeat (100) @(negedge clk);
    checks += 2;
    if (wr_cnt !== bw) begin errors++; $display("FAIL mid_lost: %0d writes after reset, required 0", wr_cnt - bw); end
    if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle_after: got %0b, required 1", idle); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_data  = 8'h00;
    test_reset();
    test_single_write();
    test_busy_poll();
    test_timeout();
    test_freeze();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
